divby3_tx: RTL and testbench

- Serial mod-3 frame transmitter. It is the sending end for our MSB-first divisible-by-3 serial detector.
- Accepts a DATA_W-bit word through a valid/ready handshake and shifts it out MSB-first. It then appends a 2-bit check field so that each transmitted frame, read as an unsigned integer, is divisible by 3.
- A downstream divby3 detector sampling tx_bit therefore reports "divisible" at every frame boundary. This holds across back-to-back frames and idle gaps.

---
 rtl/divby3_tx.sv | 159 +++++++++++++++
 tb/tb_divby3_tx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/divby3_tx.sv
// Serial mod-3 frame transmitter: DATA_W payload bits MSB-first plus a 2-bit check field.
// Optional error injection on the check LSB when DIVBY3_TX_ERRINJ_EN is defined.
module divby3_tx #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              tx_bit,
   output logic              tx_valid,
   output logic              tx_last,
   output logic              busy
`ifdef DIVBY3_TX_ERRINJ_EN
   ,
   input  logic              err_inj,
   output logic              err_sent
`endif
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, CHK1, CHK0} state_t;
   typedef enum logic [1:0] {R0 = 2'b00, R1 = 2'b01, R2 = 2'b11} res_t;

   function automatic res_t res_step(input res_t r, input logic b);
      case (r)
         R0:      return b ? R1 : R0;
         R1:      return b ? R0 : R2;
         R2:      return b ? R2 : R1;
         default: return R0;
      endcase
   endfunction

   function automatic logic [1:0] check_of(input res_t r);
      case (r)
         R1:      return 2'b10;
         R2:      return 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   state_t              state_q, state_d;
   res_t                res_q, res_d;
   logic [DATA_W-2:0]   sh_q, sh_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                bit_q, bit_d;
   logic                valid_q, valid_d;
   logic                last_q, last_d;
   logic                busy_q, busy_d;
   logic                hs;
   logic [1:0]          chk;
`ifdef DIVBY3_TX_ERRINJ_EN
   logic                err_q, err_d;
   logic                err_sent_q, err_sent_d;
`endif

   assign in_ready = (state_q == IDLE) || (state_q == CHK0);
   assign hs       = in_valid && in_ready;
   assign chk      = check_of(res_q);

   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      bit_d   = 1'b0;
      valid_d = 1'b0;
      last_d  = 1'b0;
`ifdef DIVBY3_TX_ERRINJ_EN
      err_d      = err_q;
      err_sent_d = 1'b0;
`endif
      case (state_q)
         IDLE: ;
         SHIFT: begin
            valid_d = 1'b1;
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
               // residue already includes the last payload bit, so c[1] goes out now
               state_d = CHK1;
               bit_d   = chk[1];
            end else begin
               bit_d = sh_q[DATA_W-2];
               res_d = res_step(res_q, sh_q[DATA_W-2]);
               sh_d  = sh_q << 1;
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         CHK1: begin
            state_d = CHK0;
            valid_d = 1'b1;
            last_d  = 1'b1;
`ifdef DIVBY3_TX_ERRINJ_EN
            bit_d      = chk[0] ^ err_q;
            err_sent_d = err_q;
`else
            bit_d = chk[0];
`endif
         end
         CHK0:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // an accepted word overrides IDLE/CHK0 and emits its MSB on the next edge
      if (hs) begin
         state_d = SHIFT;
         sh_d    = in_data[DATA_W-2:0];
         cnt_d   = '0;
         res_d   = res_step(R0, in_data[DATA_W-1]);
         bit_d   = in_data[DATA_W-1];
         valid_d = 1'b1;
         last_d  = 1'b0;
`ifdef DIVBY3_TX_ERRINJ_EN
         err_d      = err_inj;
         err_sent_d = 1'b0;
`endif
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         res_q   <= R0;
         sh_q    <= '0;
         cnt_q   <= '0;
         bit_q   <= 1'b0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifdef DIVBY3_TX_ERRINJ_EN
         err_q      <= 1'b0;
         err_sent_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
`ifdef DIVBY3_TX_ERRINJ_EN
         err_q      <= err_d;
         err_sent_q <= err_sent_d;
`endif
      end
   end

   assign tx_bit   = bit_q;
   assign tx_valid = valid_q;
   assign tx_last  = last_q;
   assign busy     = busy_q;
`ifdef DIVBY3_TX_ERRINJ_EN
   assign err_sent = err_sent_q;
`endif

endmodule

// File: tb/tb_divby3_tx.sv
// Bench for divby3_tx: per-cycle scoreboard of expected frame bits (4*data + check)
// plus a running mod-3 model of the tx_bit stream.
module tb_divby3_tx;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rstn;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         in_ready, tx_bit, tx_valid, tx_last, busy;
`ifdef DIVBY3_TX_ERRINJ_EN
   logic         err_inj;
   logic         err_sent;
`endif

   always #5 clk = ~clk;

   divby3_tx #(.DATA_W(W)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .tx_bit   (tx_bit),
      .tx_valid (tx_valid),
      .tx_last  (tx_last),
      .busy     (busy)
`ifdef DIVBY3_TX_ERRINJ_EN
      ,
      .err_inj  (err_inj),
      .err_sent (err_sent)
`endif
   );

   typedef struct {
      bit b;
      bit last;
      bit err;
   } exp_t;

   exp_t q[$];
   int   frame_q[$];
   int   total = 0;
   int   bad = 0;
   int   stream_res = 0;
   int   obs_frame = 0;
   int   accepted = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int frame_val(input int d, input bit e);
      int c;
      c = (3 - (d % 3)) % 3;
      if (e) c = c ^ 1;
      return 4 * d + c;
   endfunction

   task automatic push_frame(input int d, input bit e);
      int   v;
      exp_t t;
      v = frame_val(d, e);
      frame_q.push_back(v);
      for (int i = W + 1; i >= 0; i--) begin
         t.b    = v[i];
         t.last = (i == 0);
         t.err  = e;
         q.push_back(t);
      end
      accepted++;
   endtask

   // check this cycle's outputs against the scoreboard, then drive next inputs
   task automatic cycle(input bit v, input logic [W-1:0] d, input bit e);
      exp_t cur;
      bit   have, rdy;
      @(negedge clk);
      have = (q.size() > 0);
      rdy  = (q.size() <= 1);
      if (have) cur = q[0];
      else cur = '{b: 1'b0, last: 1'b0, err: 1'b0};
      chk("tx_valid", tx_valid, have);
      chk("tx_bit", tx_bit, cur.b);
      chk("tx_last", tx_last, cur.last);
      chk("busy", busy, have);
      chk("in_ready", in_ready, rdy);
`ifdef DIVBY3_TX_ERRINJ_EN
      chk("err_sent", err_sent, cur.last && cur.err);
`endif
      stream_res = (2 * stream_res + int'(tx_bit)) % 3;
      if (have) begin
         obs_frame = obs_frame * 2 + int'(tx_bit);
         if (cur.last) begin
            chk("frame", obs_frame, frame_q.pop_front());
            if (cur.err) chk("mod3_err_nonzero", stream_res != 0, 1);
            else chk("mod3_at_last", stream_res, 0);
            stream_res = 0;
            obs_frame  = 0;
         end
         void'(q.pop_front());
      end
      in_valid = v;
      in_data  = d;
`ifdef DIVBY3_TX_ERRINJ_EN
      err_inj  = e;
`endif
      if (v && rdy) push_frame(int'(d), e);
   endtask

   initial begin
      rstn     = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
`ifdef DIVBY3_TX_ERRINJ_EN
      err_inj  = 1'b0;
`endif
      repeat (3) cycle(0, '0, 0);
      @(negedge clk);
      rstn = 1'b1;

      // single frames: 0x05 -> 21, 0x07 -> 30, 0xFF -> 1020, 0x00 -> 0
      cycle(1, 8'h05, 0);
      repeat (11) cycle(0, 8'hEE, 0);
      cycle(1, 8'h07, 0);
      repeat (11) cycle(0, '0, 0);
      cycle(1, 8'hFF, 0);
      repeat (11) cycle(0, '0, 0);
      cycle(1, 8'h00, 0);
      repeat (11) cycle(0, '0, 0);

      // back-to-back with in_valid held high
      cycle(1, 8'h05, 0);
      repeat (10) cycle(1, 8'h07, 0);
      repeat (12) cycle(0, '0, 0);

      // reset during payload bit 4 of 0xA5
      cycle(1, 8'hA5, 0);
      repeat (4) cycle(0, '0, 0);
      #2 rstn = 1'b0;
      #1;
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_tx_last", tx_last, 0);
      chk("rst_tx_bit", tx_bit, 0);
      q.delete();
      frame_q.delete();
      obs_frame  = 0;
      stream_res = 0;
      @(negedge clk);
      rstn = 1'b1;
      cycle(1, 8'h03, 0);
      repeat (11) cycle(0, '0, 0);

`ifdef DIVBY3_TX_ERRINJ_EN
      // corrupted 0x05: check becomes 0,0 -> frame 20
      cycle(1, 8'h05, 1);
      repeat (11) cycle(0, '0, 0);
`endif

      // randomized words with random gaps; in_data scrambled while not ready
      begin
         int target;
         target = accepted + 1000;
         for (int n = 0; n < 30000 && accepted < target; n++) begin
            bit v, e;
            v = ($urandom_range(0, 3) != 0);
`ifdef DIVBY3_TX_ERRINJ_EN
            e = ($urandom_range(0, 7) == 0);
`else
            e = 1'b0;
`endif
            cycle(v, W'($urandom), e);
         end
         chk("random_words_accepted", accepted >= target, 1);
      end
      repeat (12) cycle(0, '0, 0);
      chk("scoreboard_drained", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
